// File: rtl/lock_pkg.sv
// Shared types and constants for the digital-lock controller.
package lock_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned FAIL_W     = 3;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        OPEN    = 2'd1,
        PROGRAM = 2'd2,
        LOCKOUT = 2'd3
    } state_e;

    // Four display/entry nibbles; index 3 is the leftmost digit.
    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digit_buf_t;

    localparam logic [DIGIT_W-1:0] KEY_ENTER  = 4'd10;
    localparam logic [DIGIT_W-1:0] KEY_CLEAR  = 4'd11;
    localparam logic [DIGIT_W-1:0] KEY_PROG   = 4'd12;
    localparam logic [DIGIT_W-1:0] KEY_LOCK   = 4'd13;
    localparam logic [DIGIT_W-1:0] BLANK      = 4'hF;
    localparam logic [DIGIT_W-1:0] MASK_DIGIT = 4'd8;

    localparam digit_buf_t BLANK_BUF = {NUM_DIGITS{BLANK}};

    function automatic logic is_digit(input logic [DIGIT_W-1:0] k);
        return k <= 4'd9;
    endfunction

    function automatic digit_buf_t shift_in(input digit_buf_t b, input logic [DIGIT_W-1:0] k);
        return {b[2:0], k};
    endfunction

endpackage

// File: rtl/lockout_timer.sv
// Down-counter that paces the LOCKOUT period; done pulses in the cycle the count reaches 0.
module lockout_timer #(
    parameter int unsigned LOCKOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int unsigned TMR_W = $clog2(LOCKOUT_CYCLES + 1);

    logic [TMR_W-1:0] count_q, count_d;
    logic             done_q, done_d;

    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        if (start) begin
            count_d = TMR_W'(LOCKOUT_CYCLES);
        end else if (count_q != '0) begin
            count_d = count_q - TMR_W'(1);
            done_d  = (count_q == TMR_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: rtl/lock_entry.sv
// Keypad lock controller: collects a 4-digit code, opens/reprograms, locks out after repeated failures.
// Optional LOCK_MASK_DISPLAY_EN: digits typed in ENTRY are shown as 4'd8 instead of their value.
module lock_entry
    import lock_pkg::*;
#(
    parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    input  logic       key_valid,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       unlocked,
    output logic       alarm
);

    state_e            state_q, state_d;
    digit_buf_t        buf_q, buf_d;
    digit_buf_t        code_q, code_d;
    digit_buf_t        digits_q, digits_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic [FAIL_W-1:0] fail_inc;
    logic              unlocked_q, unlocked_d;
    logic              alarm_q, alarm_d;
    logic              key_ok;
    logic              timer_start;
    logic              timer_done;

    lockout_timer #(
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .start(timer_start),
        .done (timer_done)
    );

    assign key_ok   = key_valid && (key <= KEY_LOCK);
    assign fail_inc = fail_q + FAIL_W'(1);

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        code_d      = code_q;
        cnt_d       = cnt_q;
        fail_d      = fail_q;
        timer_start = 1'b0;
        digits_d    = BLANK_BUF;

        case (state_q)
            ENTRY: begin
                if (key_ok) begin
                    if (is_digit(key)) begin
                        buf_d = shift_in(buf_q, key);
                        cnt_d = (cnt_q == CNT_W'(4)) ? cnt_q : cnt_q + CNT_W'(1);
                    end else if (key == KEY_CLEAR) begin
                        buf_d = BLANK_BUF;
                        cnt_d = '0;
                    end else if (key == KEY_ENTER) begin
                        buf_d = BLANK_BUF;
                        cnt_d = '0;
                        if (cnt_q == CNT_W'(4) && buf_q == code_q) begin
                            state_d = OPEN;
                            fail_d  = '0;
                        end else begin
                            fail_d = fail_inc;
                            if (fail_inc == FAIL_W'(MAX_TRIES)) begin
                                state_d     = LOCKOUT;
                                timer_start = 1'b1;
                            end
                        end
                    end
                end
            end
            OPEN: begin
                if (key_ok && key == KEY_LOCK) begin
                    state_d = ENTRY;
                    buf_d   = BLANK_BUF;
                    cnt_d   = '0;
                end else if (key_ok && key == KEY_PROG) begin
                    state_d = PROGRAM;
                    buf_d   = BLANK_BUF;
                    cnt_d   = '0;
                end
            end
            PROGRAM: begin
                if (key_ok) begin
                    if (is_digit(key)) begin
                        buf_d = shift_in(buf_q, key);
                        cnt_d = (cnt_q == CNT_W'(4)) ? cnt_q : cnt_q + CNT_W'(1);
                    end else if (key == KEY_CLEAR) begin
                        buf_d = BLANK_BUF;
                        cnt_d = '0;
                    end else if (key == KEY_ENTER && cnt_q == CNT_W'(4)) begin
                        code_d  = buf_q;
                        state_d = OPEN;
                        buf_d   = BLANK_BUF;
                        cnt_d   = '0;
                    end else if (key == KEY_LOCK) begin
                        state_d = OPEN;
                        buf_d   = BLANK_BUF;
                        cnt_d   = '0;
                    end
                end
            end
            LOCKOUT: begin
                if (timer_done) begin
                    state_d = ENTRY;
                    fail_d  = '0;
                end
            end
            default: state_d = ENTRY;
        endcase

        // Registered outputs reflect the state and buffer being entered this edge.
        unlocked_d = (state_d == OPEN) || (state_d == PROGRAM);
        alarm_d    = (state_d == LOCKOUT);
        if (state_d == PROGRAM) begin
            digits_d = buf_d;
        end else if (state_d == ENTRY) begin
`ifdef LOCK_MASK_DISPLAY_EN
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                digits_d[i] = (buf_d[i] == BLANK) ? BLANK : MASK_DIGIT;
            end
`else
            digits_d = buf_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ENTRY;
            buf_q      <= BLANK_BUF;
            code_q     <= digit_buf_t'(DEFAULT_CODE);
            digits_q   <= BLANK_BUF;
            cnt_q      <= '0;
            fail_q     <= '0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            code_q     <= code_d;
            digits_q   <= digits_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            unlocked_q <= unlocked_d;
            alarm_q    <= alarm_d;
        end
    end

    assign digit3   = digits_q[3];
    assign digit2   = digits_q[2];
    assign digit1   = digits_q[1];
    assign digit0   = digits_q[0];
    assign unlocked = unlocked_q;
    assign alarm    = alarm_q;

endmodule

// File: tb/tb_lock_entry.sv
// Self-checking bench for lock_entry: behavioural lock model compared every cycle plus directed literal checks.
module tb_lock_entry;

    localparam logic [15:0] DEF_CODE = 16'h1234;
    localparam int          TRIES    = 3;
    localparam int          LCYC     = 1000;
`ifdef LOCK_MASK_DISPLAY_EN
    localparam bit MASKED = 1'b1;
`else
    localparam bit MASKED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'd0;
    logic       key_valid = 1'b0;
    logic [3:0] digit3, digit2, digit1, digit0;
    logic       unlocked, alarm;

    int total = 0;
    int bad   = 0;

    lock_entry #(
        .DEFAULT_CODE  (DEF_CODE),
        .MAX_TRIES     (TRIES),
        .LOCKOUT_CYCLES(LCYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .key_valid(key_valid),
        .digit3   (digit3),
        .digit2   (digit2),
        .digit1   (digit1),
        .digit0   (digit0),
        .unlocked (unlocked),
        .alarm    (alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] disp();
        return {digit3, digit2, digit1, digit0};
    endfunction

    // ---------------- behavioural model ----------------
    // States: 0 entry, 1 open, 2 programming, 3 lockout
    int m_state, m_cnt, m_fail, m_rem;
    int m_buf[4];
    int m_code[4];
    bit model_ok = 1'b0;

    function automatic void m_clear();
        for (int i = 0; i < 4; i++) m_buf[i] = 15;
        m_cnt = 0;
    endfunction

    function automatic void m_push(input int k);
        for (int i = 3; i > 0; i--) m_buf[i] = m_buf[i-1];
        m_buf[0] = k;
        if (m_cnt < 4) m_cnt++;
    endfunction

    function automatic bit m_match();
        for (int i = 0; i < 4; i++) if (m_buf[i] != m_code[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        int k;
        k = int'(key);
        if (rst) begin
            m_state = 0; m_fail = 0; m_rem = 0;
            m_clear();
            for (int i = 0; i < 4; i++) m_code[i] = int'((DEF_CODE >> (4*i)) & 16'hF);
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (m_state == 3) begin
                if (m_rem == 0) begin m_state = 0; m_fail = 0; end
                else m_rem--;
            end else if (key_valid && k < 14) begin
                case (m_state)
                    0: begin
                        if (k < 10) m_push(k);
                        else if (k == 11) m_clear();
                        else if (k == 10) begin
                            if (m_cnt == 4 && m_match()) begin m_state = 1; m_fail = 0; end
                            else begin
                                m_fail++;
                                if (m_fail == TRIES) begin m_state = 3; m_rem = LCYC; end
                            end
                            m_clear();
                        end
                    end
                    1: begin
                        if (k == 13) begin m_state = 0; m_clear(); end
                        else if (k == 12) begin m_state = 2; m_clear(); end
                    end
                    2: begin
                        if (k < 10) m_push(k);
                        else if (k == 11) m_clear();
                        else if (k == 10 && m_cnt == 4) begin
                            for (int i = 0; i < 4; i++) m_code[i] = m_buf[i];
                            m_state = 1; m_clear();
                        end else if (k == 13) begin m_state = 1; m_clear(); end
                    end
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [15:0] m_digits();
        logic [15:0] d;
        d = 16'hFFFF;
        if (m_state == 0 || m_state == 2) begin
            for (int i = 0; i < 4; i++) begin
                if (m_state == 0 && MASKED && m_buf[i] != 15) d[4*i +: 4] = 4'd8;
                else d[4*i +: 4] = 4'(m_buf[i]);
            end
        end
        return d;
    endfunction

    // Per-cycle comparison against the model, just after each active edge.
    always @(posedge clk) begin
        #1;
        if (model_ok) begin
            chk("cyc_digits",   32'(disp()), 32'(m_digits()));
            chk("cyc_unlocked", 32'(unlocked), 32'(m_state == 1 || m_state == 2));
            chk("cyc_alarm",    32'(alarm), 32'(m_state == 3));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] c);
        logic [15:0] v;
        v = c;
        for (int i = 3; i >= 0; i--) press(v[4*i +: 4]);
        press(4'd10);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] seq;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_digits", 32'(disp()), 32'h0000FFFF);
        chk("reset_unlocked", 32'(unlocked), 32'd0);
        chk("reset_alarm", 32'(alarm), 32'd0);

        // 1: correct code opens
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        chk("t1_entry_digits", 32'(disp()), MASKED ? 32'h8888 : 32'h1234);
        press(4'd10);
        chk("t1_unlocked", 32'(unlocked), 32'd1);
        chk("t1_open_blank", 32'(disp()), 32'h0000FFFF);
        chk("t1_alarm", 32'(alarm), 32'd0);
        press(4'd13);
        chk("t1_relock", 32'(unlocked), 32'd0);

        // 2: five digits, oldest dropped
        press(4'd9);
        seq = 16'h1234;
        enter_code(seq);
        chk("t2_unlocked", 32'(unlocked), 32'd1);
        press(4'd13);

        // 3: three wrong codes -> lockout, keys ignored throughout
        enter_code(16'h0000);
        enter_code(16'h0000);
        chk("t3_no_alarm_yet", 32'(alarm), 32'd0);
        enter_code(16'h0000);
        chk("t3_alarm", 32'(alarm), 32'd1);
        n = 0;
        while (alarm && n < 1200) begin
            key = ((n % 5) == 4) ? 4'd10 : 4'((n % 5) + 1);
            key_valid = 1'b1;
            @(negedge clk);
            n++;
        end
        key_valid = 1'b0;
        chk("t3_lockout_len", 32'(n), 32'(LCYC + 1));
        chk("t3_alarm_clear", 32'(alarm), 32'd0);
        chk("t3_entry_blank", 32'(disp()), 32'h0000FFFF);

        // 4: reprogram to 5678
        enter_code(16'h1234);
        press(4'd12);
        chk("t4_prog_unlocked", 32'(unlocked), 32'd1);
        press(4'd5); press(4'd6); press(4'd7); press(4'd8);
        chk("t4_prog_digits", 32'(disp()), 32'h5678);
        press(4'd10);
        press(4'd13);
        chk("t4_locked", 32'(unlocked), 32'd0);
        enter_code(16'h1234);
        chk("t4_old_code_rejected", 32'(unlocked), 32'd0);
        enter_code(16'h5678);
        chk("t4_new_code_opens", 32'(unlocked), 32'd1);
        // short ENTER in PROGRAM is ignored; LOCK returns to OPEN keeping the code
        press(4'd12); press(4'd9); press(4'd10);
        chk("t4_short_enter_ignored", 32'(disp()), 32'hFFF9);
        press(4'd13);
        chk("t4_prog_lock_open", 32'(unlocked), 32'd1);
        press(4'd13);

        // 5: clear, then empty ENTERs count as failures
        press(4'd1); press(4'd2);
        chk("t5_partial", 32'(disp()), MASKED ? 32'hFF88 : 32'hFF12);
        press(4'd11);
        chk("t5_clear", 32'(disp()), 32'h0000FFFF);
        press(4'd14); press(4'd15);
        chk("t5_keys14_15_ignored", 32'(disp()), 32'h0000FFFF);
        press(4'd10);
        chk("t5_still_locked", 32'(unlocked), 32'd0);
        press(4'd10);
        chk("t5_two_fails_no_alarm", 32'(alarm), 32'd0);
        press(4'd10);
        chk("t6_lockout", 32'(alarm), 32'd1);

        // 6: reset in LOCKOUT with a simultaneous key
        repeat (5) @(negedge clk);
        rst = 1'b1; key = 4'd10; key_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; key_valid = 1'b0;
        chk("t6_reset_alarm", 32'(alarm), 32'd0);
        chk("t6_reset_digits", 32'(disp()), 32'h0000FFFF);
        chk("t6_reset_unlocked", 32'(unlocked), 32'd0);
        enter_code(16'h1234);
        chk("t6_default_code_back", 32'(unlocked), 32'd1);
        press(4'd13);
        press(4'd7);
        chk("t6_digit0", 32'(digit0), MASKED ? 32'd8 : 32'd7);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
